// File: rtl/alu_op_sequencer_pkg.sv
// Shared opcode constants, state encoding and instruction classes for the
// fetch/execute control sequencer.
package alu_op_sequencer_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    localparam logic [4:0] ALU_INC = 5'b11111;
    localparam logic [4:0] ALU_NOP = 5'b00000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6
    } state_t;

    typedef enum logic [1:0] {
        CLS_BIN,
        CLS_WIDE,
        CLS_UN,
        CLS_ILLEGAL
    } op_class_t;

    // The step that writes the final result back; done is raised here and the
    // sequencer then either idles or chains into the next fetch.
    function automatic logic is_last_step(input state_t st, input op_class_t cls);
        return ((st == ST_T4) && (cls == CLS_UN))  ||
               ((st == ST_T5) && (cls == CLS_BIN)) ||
               ((st == ST_T6) && (cls == CLS_WIDE));
    endfunction

endpackage

// File: rtl/alu_op_sequencer_decode.sv
// Combinational opcode classifier: maps the 5-bit opcode onto the execute
// sequence it needs.
module alu_op_decode
    import alu_op_sequencer_pkg::*;
(
    input  logic [4:0] opcode,
    output op_class_t  op_class
);

    always_comb begin
        op_class = CLS_ILLEGAL;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL: op_class = CLS_BIN;
            OP_MUL, OP_DIV:                  op_class = CLS_WIDE;
            OP_NEG, OP_NOT:                  op_class = CLS_UN;
            default:                         op_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Control-step sequencer for a bus-based datapath: fetches one instruction and
// issues the per-step register/ALU strobes for its execute phase.
//
// state | meaning
// IDLE  | waiting for start
// T0    | PC to MAR, ALU increments PC into Z
// T1    | PC <- Z, memory read into MDR; holds until mem_ready
// T2    | MDR to IR
// T3-T6 | execute steps, content depends on the opcode class
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int REG_FIELD_W = 4,
    parameter bit CONTINUOUS  = 1'b0,
    localparam int NUM_REGS   = 2 ** REG_FIELD_W
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                start,
    input  logic                mem_ready,
    input  logic [31:0]         ir,
    output logic [NUM_REGS-1:0] reg_in,
    output logic [NUM_REGS-1:0] reg_out,
    output logic                pc_out,
    output logic                pc_in,
    output logic                mar_in,
    output logic                mdr_in,
    output logic                mdr_out,
    output logic                read,
    output logic                ir_in,
    output logic                y_in,
    output logic                zlow_in,
    output logic                zhigh_in,
    output logic                zlow_out,
    output logic                zhigh_out,
    output logic                hi_in,
    output logic                lo_in,
    output logic [4:0]          alu_op,
    output logic                busy,
    output logic                done,
    output logic                illegal
);

    state_t                 state;
    state_t                 state_nxt;
    op_class_t              op_class;
    logic [4:0]             opcode;
    logic [REG_FIELD_W-1:0] ra;
    logic [REG_FIELD_W-1:0] rb;
    logic [REG_FIELD_W-1:0] rc;
    logic                   last_step;
    logic                   unused_ir_bits;

    assign opcode = ir[31:27];
    assign ra     = ir[26 -: REG_FIELD_W];
    assign rb     = ir[26 - REG_FIELD_W -: REG_FIELD_W];
    assign rc     = ir[26 - 2 * REG_FIELD_W -: REG_FIELD_W];

    // Low IR bits carry immediates the sequencer never looks at.
    assign unused_ir_bits = ^ir;

    alu_op_decode u_decode (
        .opcode   (opcode),
        .op_class (op_class)
    );

    assign last_step = is_last_step(state, op_class);

    always_ff @(posedge clock) begin
        if (clear) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_T0;
            ST_T0:   state_nxt = ST_T1;
            ST_T1:   if (mem_ready) state_nxt = ST_T2;
            ST_T2:   state_nxt = ST_T3;
            ST_T3:   state_nxt = (op_class == CLS_ILLEGAL) ? ST_IDLE : ST_T4;
            ST_T4:   state_nxt = ST_T5;
            ST_T5:   state_nxt = (op_class == CLS_WIDE) ? ST_T6 : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        // Write-back step: chain straight into the next fetch when allowed.
        if (last_step) begin
            state_nxt = (CONTINUOUS && start) ? ST_T0 : ST_IDLE;
        end
    end

    always_comb begin
        reg_in    = '0;
        reg_out   = '0;
        pc_out    = 1'b0;
        pc_in     = 1'b0;
        mar_in    = 1'b0;
        mdr_in    = 1'b0;
        mdr_out   = 1'b0;
        read      = 1'b0;
        ir_in     = 1'b0;
        y_in      = 1'b0;
        zlow_in   = 1'b0;
        zhigh_in  = 1'b0;
        zlow_out  = 1'b0;
        zhigh_out = 1'b0;
        hi_in     = 1'b0;
        lo_in     = 1'b0;
        alu_op    = ALU_NOP;
        illegal   = 1'b0;
        busy      = (state != ST_IDLE);
        done      = last_step;

        case (state)
            ST_T0: begin
                pc_out  = 1'b1;
                mar_in  = 1'b1;
                zlow_in = 1'b1;
                alu_op  = ALU_INC;
            end
            ST_T1: begin
                zlow_out = 1'b1;
                pc_in    = 1'b1;
                read     = 1'b1;
                mdr_in   = 1'b1;
            end
            ST_T2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
            end
            ST_T3: begin
                case (op_class)
                    CLS_BIN: begin
                        reg_out[rb] = 1'b1;
                        y_in        = 1'b1;
                    end
                    CLS_UN: begin
                        reg_out[rb] = 1'b1;
                        alu_op      = opcode;
                        zlow_in     = 1'b1;
                    end
                    CLS_WIDE: begin
                        reg_out[ra] = 1'b1;
                        y_in        = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            ST_T4: begin
                case (op_class)
                    CLS_BIN: begin
                        reg_out[rc] = 1'b1;
                        alu_op      = opcode;
                        zlow_in     = 1'b1;
                    end
                    CLS_UN: begin
                        zlow_out   = 1'b1;
                        reg_in[ra] = 1'b1;
                    end
                    CLS_WIDE: begin
                        reg_out[rb] = 1'b1;
                        alu_op      = opcode;
                        zlow_in     = 1'b1;
                        zhigh_in    = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (op_class)
                    CLS_BIN: begin
                        zlow_out   = 1'b1;
                        reg_in[ra] = 1'b1;
                    end
                    CLS_WIDE: begin
                        zlow_out = 1'b1;
                        lo_in    = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                if (op_class == CLS_WIDE) begin
                    zhigh_out = 1'b1;
                    hi_in     = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter REG_FIELD_W, default 4, meaning register-index field width; NUM_REGS = 2**REG_FIELD_W; legal range 1..9.
REQ-002 SHALL have parameter CONTINUOUS, default 0, meaning that when it is 1 and start is high in the done cycle, the next state is T0 instead of IDLE.
REQ-003 SHALL have one clock and a synchronous, active-high reset: port clock, input, 1 bit, rising-edge clock.
REQ-004 SHALL have port clear, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1 bit, begin fetch/execute of one instruction.
REQ-006 SHALL have port mem_ready, input, 1 bit, memory read data valid.
REQ-007 SHALL have port ir, input, 32 bits, datapath IR contents, valid from T3 onward.
REQ-008 SHALL have ports reg_in and reg_out, output, NUM_REGS bits each, one-hot register load and drive selects.
REQ-009 SHALL have 1-bit outputs pc_out, pc_in, mar_in, mdr_in, mdr_out, read, ir_in, y_in, zlow_in, zhigh_in, zlow_out, zhigh_out, hi_in and lo_in, each a datapath strobe.
REQ-010 SHALL have port alu_op, output, 5 bits, ALU opcode.
REQ-011 SHALL have outputs busy, done and illegal, 1 bit each, status.

Function
REQ-012 SHALL decode ir fields as follows: opcode=ir[31:27], ra=next REG_FIELD_W bits down, rb=next, rc=next.
REQ-013 SHALL classify opcodes into these classes:
- BIN: ADD 00011, SUB 00100, AND 00101, OR 00110, ROR 00111, ROL 01000, SHR 01001, SHRA 01010, SHL 01011.
- WIDE: MUL 01111, DIV 10000.
- UN: NEG 10001, NOT 10010.
- Every other opcode is ILLEGAL.
REQ-014 SHALL implement the states IDLE, T0, T1, T2, T3, T4, T5 and T6, with all outputs Moore-decoded from state and ir, and every strobe not listed for a state driven to 0.
REQ-015 In IDLE, the block SHALL go to T0 if start=1, otherwise remain in IDLE.
REQ-016 In T0, the block SHALL assert pc_out, mar_in, zlow_in and alu_op=11111 (PC increment), then go to T1.
REQ-017 In T1, the block SHALL assert zlow_out, pc_in, read and mdr_in; it SHALL hold T1 while mem_ready=0 and go to T2 on mem_ready=1.
REQ-018 In T2, the block SHALL assert mdr_out and ir_in, then go to T3.
REQ-019 For ILLEGAL opcodes, T3 SHALL assert illegal for one cycle with no strobes and then go to IDLE; done SHALL NOT be asserted.
REQ-020 For BIN instructions:
- T3: reg_out[rb] and y_in.
- T4: reg_out[rc], alu_op=opcode and zlow_in.
- T5: zlow_out, reg_in[ra] and done.
REQ-021 For UN instructions:
- T3: reg_out[rb], alu_op=opcode and zlow_in.
- T4: zlow_out, reg_in[ra] and done.
REQ-022 For WIDE instructions:
- T3: reg_out[ra] and y_in.
- T4: reg_out[rb], alu_op=opcode, zlow_in and zhigh_in.
- T5: zlow_out and lo_in.
- T6: zhigh_out, hi_in and done.
REQ-023 After the done cycle, the block SHALL go to T0 if CONTINUOUS=1 and start=1, otherwise to IDLE.
REQ-024 alu_op SHALL be 00000 in every state not listed above.
REQ-025 reg_in and reg_out SHALL each have at most one bit set in every cycle, and SHALL be all-zero outside the listed states.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 start SHALL be ignored while busy=1.
REQ-028 When ra=rb or ra=rc, the sequence SHALL be unchanged: the read occurs in an earlier cycle than the write.

Reset
REQ-029 On clear=1 at a rising edge, the state SHALL become IDLE regardless of the current state, including a pending T1 wait.
REQ-030 In the cycle following a clear, all outputs SHALL be 0.
REQ-031 clear SHALL take priority over start and mem_ready.

Structure
REQ-032 A shared package SHALL hold the opcode constants, the ALU increment constant 11111, the state enum and the class enum {BIN, WIDE, UN, ILLEGAL}.
REQ-033 One sub-module, alu_op_decode, SHALL be combinational and map opcode to class.

Verification
REQ-034 The bench SHALL cover: start with mem_ready=1 and ir=0x92800000 (NOT r5,r0) -> T3 shows reg_out=0x0001 and alu_op=10010; T4 shows reg_in=0x0020 and done; the sequence takes 5 cycles after IDLE.
REQ-035 The bench SHALL cover: ir=0x19910000 (ADD r3,r2,r2) -> T3 reg_out[2] with y_in; T4 reg_out[2] with alu_op=00011; T5 reg_in[3] with done.
REQ-036 The bench SHALL cover: ir=0x7A000000 (MUL r4,r0) -> T5 asserts lo_in and T6 asserts hi_in with done; zlow_in and zhigh_in are both asserted in T4.
REQ-037 The bench SHALL cover: mem_ready held 0 for 3 cycles -> read stays asserted for 4 cycles and T2 follows the edge where mem_ready=1.
REQ-038 The bench SHALL cover: ir=0xF8000000 -> illegal pulses for 1 cycle, done stays 0 and the state returns to IDLE.
REQ-039 The bench SHALL cover: clear asserted in T4 of a BIN instruction -> the next cycle has all outputs 0 and busy=0; with CONTINUOUS=1 and start held, done is followed directly by T0 (pc_out=1).
